motor_pwm_drive: RTL

- Motor-side stage downstream of the switch/command inputs of the drive block; produces MotorPWM and MotorDirection for the H-bridge.
- Converts a speed command and direction command into slew-limited PWM.
- Enforces ramp-to-zero plus dead time before any direction reversal, so the bridge never reverses under load.
- Sits beside the encoder counter in the drive block; it shares the same clock and reset.

---
 rtl/drive_pkg.sv | 24 ++
 rtl/motor_pwm_drive_pwm_gen.sv | 64 ++++++
 rtl/motor_pwm_drive.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - shared types and defaults for the motor PWM drive
//
// Holds the drive FSM state type, default parameter values and the
// counter-width helper used by the drive top level and the PWM generator.
package drive_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DECEL = 2'd1,
        DEAD  = 2'd2
    } drive_state_t;

    localparam int DUTY_W_DEF   = 8;
    localparam int PRESCALE_DEF = 8;
    localparam int RAMP_DIV_DEF = 50000;
    localparam int DEADTIME_DEF = 50000;
    localparam int CLK_HZ       = 50_000_000;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/motor_pwm_drive_pwm_gen.sv
// rtl/motor_pwm_drive_pwm_gen.sv - prescaled PWM generator with period-boundary duty latch
//
// Ports:
//   CLOCK_50  in   system clock
//   Reset     in   asynchronous active-high reset
//   duty      in   requested duty (0 = off, 2^DUTY_W-1 = always on)
//   pwm       out  registered PWM output
module pwm_gen
    import drive_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    localparam int                PRE_W    = cnt_w(PRESCALE);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    // Period runs 0..2^DUTY_W-2 so that a duty of 2^DUTY_W-1 is 100 %.
    localparam logic [DUTY_W-1:0] PER_LAST = DUTY_W'((1 << DUTY_W) - 2);

    logic [PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0] r_period_cnt;
    logic [DUTY_W-1:0] r_applied;
    logic              r_pwm;

    logic w_tick;
    logic w_wrap;
    logic w_duty_zero;

    assign w_tick      = (r_pre == PRE_LAST);
    assign w_wrap      = w_tick && (r_period_cnt == PER_LAST);
    assign w_duty_zero = (duty == '0);

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_pre        <= '0;
            r_period_cnt <= '0;
            r_applied    <= '0;
            r_pwm        <= 1'b0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_period_cnt <= (r_period_cnt == PER_LAST) ? '0 : r_period_cnt + 1'b1;
            end
            // New duty takes effect exactly as the period restarts at count 0,
            // prescale 0. A zero request cuts the output at once instead: it
            // can only shorten a pulse, and it guarantees the bridge is idle
            // for the whole dead time before a direction change.
            if (w_duty_zero) begin
                r_applied <= '0;
            end else if (w_wrap) begin
                r_applied <= duty;
            end
            r_pwm <= !w_duty_zero && (r_period_cnt < r_applied);
        end
    end

    assign pwm = r_pwm;

endmodule

// File: rtl/motor_pwm_drive.sv
// rtl/motor_pwm_drive.sv - slew-limited PWM motor drive with safe direction reversal
//
// Ports:
//   CLOCK_50        in   system clock (50 MHz)
//   Reset           in   asynchronous active-high reset
//   enable          in   0 forces the ramp target to 0
//   dir_cmd         in   requested direction (1 = forward)
//   speed_cmd       in   requested duty magnitude
//   MotorPWM        out  registered PWM to the H-bridge
//   MotorDirection  out  registered bridge direction
//   duty_now        out  current ramped duty
//   reversing       out  high while decelerating or in dead time for a reversal
module motor_pwm_drive
    import drive_pkg::*;
#(
    parameter int DUTY_W   = DUTY_W_DEF,
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int RAMP_DIV = RAMP_DIV_DEF,
    parameter int DEADTIME = DEADTIME_DEF
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              enable,
    input  logic              dir_cmd,
    input  logic [DUTY_W-1:0] speed_cmd,
    output logic              MotorPWM,
    output logic              MotorDirection,
    output logic [DUTY_W-1:0] duty_now,
    output logic              reversing
);

    localparam int                RAMP_W    = cnt_w(RAMP_DIV);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam int                DEAD_W    = cnt_w(DEADTIME);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    // Two-flop synchronisers. speed_cmd bits may be caught mid-change, which
    // is harmless since the ramp only ever moves one LSB per step.
    logic              r_en_meta,  r_en_s;
    logic              r_dir_meta, r_dir_s;
    logic [DUTY_W-1:0] r_spd_meta, r_spd_s;

    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_dir;
    drive_state_t      r_state;

    drive_state_t      w_next_state;
    logic              w_ramp_tick;
    logic              w_dead_done;
    logic [DUTY_W-1:0] w_target;
    logic              w_reversing;
    logic              w_pwm;

    assign w_ramp_tick = (r_ramp_cnt == RAMP_LAST);
    assign w_dead_done = (r_state == DEAD) && (r_dead_cnt == DEAD_LAST);

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_en_meta  <= 1'b0;
            r_en_s     <= 1'b0;
            r_dir_meta <= 1'b0;
            r_dir_s    <= 1'b0;
            r_spd_meta <= '0;
            r_spd_s    <= '0;
        end else begin
            r_en_meta  <= enable;
            r_en_s     <= r_en_meta;
            r_dir_meta <= dir_cmd;
            r_dir_s    <= r_dir_meta;
            r_spd_meta <= speed_cmd;
            r_spd_s    <= r_spd_meta;
        end
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                // A direction mismatch while disabled is deliberately ignored.
                if (r_en_s && (r_dir_s != r_dir)) begin
                    w_next_state = DECEL;
                end
            end
            DECEL: begin
                if (r_dir_s == r_dir) begin
                    w_next_state = RUN;
                end else if (r_duty == '0) begin
                    w_next_state = DEAD;
                end
            end
            DEAD: begin
                if (w_dead_done) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_reversing = (r_state != RUN);
        w_target    = '0;
        if ((r_state == RUN) && r_en_s) begin
            w_target = r_spd_s;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_ramp_cnt <= '0;
            r_dead_cnt <= '0;
            r_duty     <= '0;
            r_dir      <= 1'b0;
        end else begin
            r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;

            if (w_ramp_tick) begin
                if (r_duty < w_target) begin
                    r_duty <= r_duty + 1'b1;
                end else if (r_duty > w_target) begin
                    r_duty <= r_duty - 1'b1;
                end
            end

            // Held at zero outside DEAD, so it is already clear on entry and
            // input activity during DEAD cannot restart it.
            if (r_state != DEAD) begin
                r_dead_cnt <= '0;
            end else if (!w_dead_done) begin
                r_dead_cnt <= r_dead_cnt + 1'b1;
            end

            if (w_dead_done) begin
                r_dir <= r_dir_s;
            end
        end
    end

    pwm_gen #(
        .DUTY_W   (DUTY_W),
        .PRESCALE (PRESCALE)
    ) u_pwm_gen (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .duty     (r_duty),
        .pwm      (w_pwm)
    );

    assign MotorPWM       = w_pwm;
    assign MotorDirection = r_dir;
    assign duty_now       = r_duty;
    assign reversing      = w_reversing;

endmodule
